// File: rtl/minterm_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : minterm_sweep_ctrl
// Purpose  : Exhaustive sweep sequencer for a combinational sum-of-products
//            block. Drives every input combination, compares the sampled
//            function output against a golden on-set / don't-care mask, and
//            streams each mismatch out over a valid/ready report port.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start_i, abort_i   - begin / terminate a sweep
//            on_mask_i, dc_mask_i - golden on-set and don't-care set
//            vars_out_o         - registered variable vector (MSB = var A)
//            f_in_i             - function output for vars_out_o
//            busy_o, done_o, pass_o - status / verdict
//            mismatch_cnt_o, first_fail_idx_o - sweep statistics
//            fail_valid_o, fail_ready_i, fail_idx_o, fail_got_o - report port
// Revision : 1.0 - initial release
// ============================================================================
module minterm_sweep_ctrl #(
  parameter int N_VARS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [(1<<N_VARS)-1:0] on_mask_i,
  input  logic [(1<<N_VARS)-1:0] dc_mask_i,
  output logic [N_VARS-1:0]     vars_out_o,
  input  logic                  f_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [N_VARS:0]       mismatch_cnt_o,
  output logic [N_VARS-1:0]     first_fail_idx_o,
  output logic                  fail_valid_o,
  input  logic                  fail_ready_i,
  output logic [N_VARS-1:0]     fail_idx_o,
  output logic                  fail_got_o
);

  localparam int NI = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_STALL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_VARS-1:0]   idx_q, idx_d;
  logic [NI-1:0]       on_mask_q, on_mask_d;
  logic [NI-1:0]       dc_mask_q, dc_mask_d;
  logic [N_VARS:0]     cnt_q, cnt_d;
  logic [N_VARS-1:0]   first_q, first_d;
  logic                pass_q, pass_d;
  logic                fvalid_q, fvalid_d;
  logic [N_VARS-1:0]   fidx_q, fidx_d;
  logic                fgot_q, fgot_d;

  logic                expected;
  logic                mismatch;
  logic                slot_free;
  logic                commit;
  logic                advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      on_mask_q <= '0;
      dc_mask_q <= '0;
      cnt_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
      fvalid_q  <= 1'b0;
      fidx_q    <= '0;
      fgot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      on_mask_q <= on_mask_d;
      dc_mask_q <= dc_mask_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
      fvalid_q  <= fvalid_d;
      fidx_q    <= fidx_d;
      fgot_q    <= fgot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    on_mask_d = on_mask_q;
    dc_mask_d = dc_mask_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    pass_d    = pass_q;
    fvalid_d  = fvalid_q;
    fidx_d    = fidx_q;
    fgot_d    = fgot_q;
    commit    = 1'b0;
    advance   = 1'b0;

    expected  = on_mask_q[idx_q];
    mismatch  = !dc_mask_q[idx_q] && (f_in_i != expected);
    slot_free = !fvalid_q || fail_ready_i;

    // Accepted report retires unless a new commit below overwrites it.
    if (fvalid_q && fail_ready_i) begin
      fvalid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          on_mask_d = on_mask_i;
          dc_mask_d = dc_mask_i;
          cnt_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          idx_d     = '0;
          state_d   = S_SWEEP;
        end
      end
      S_SWEEP, S_STALL: begin
        if (abort_i) begin
          // Abort wins over any compare in the same cycle.
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (mismatch && !slot_free) begin
          state_d = S_STALL;
        end else begin
          commit  = mismatch;
          advance = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (commit) begin
      fvalid_d = 1'b1;
      fidx_d   = idx_q;
      fgot_d   = f_in_i;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == '0) begin
        first_d = idx_q;
      end
    end

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        // Verdict is registered on entry to DONE so it is valid with done.
        idx_d   = '0;
        pass_d  = (cnt_d == '0);
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_SWEEP;
      end
    end
  end

  assign vars_out_o       = idx_q;
  assign busy_o           = (state_q == S_SWEEP) || (state_q == S_STALL);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign mismatch_cnt_o   = cnt_q;
  assign first_fail_idx_o = first_q;
  assign fail_valid_o     = fvalid_q;
  assign fail_idx_o       = fidx_q;
  assign fail_got_o       = fgot_q;

endmodule
`default_nettype wire

// File: tb/tb_minterm_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_minterm_sweep_ctrl
// Purpose  : Directed self-checking bench for minterm_sweep_ctrl (N_VARS=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_minterm_sweep_ctrl;

  localparam int N_VARS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [31:0] on_mask;
  logic [31:0] dc_mask;
  logic [4:0]  vars_out;
  logic        f_in;
  logic        busy;
  logic        done;
  logic        pass_o;
  logic [5:0]  mcnt;
  logic [4:0]  first_idx;
  logic        fvalid;
  logic        fready;
  logic [4:0]  fidx;
  logic        fgot;

  int n_cmp  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int mode   = 0;
  int done_seen = 0;
  int fv_seen   = 0;
  int snap;

  always #5 clk = ~clk;

  // Model of the function under test, selected per scenario.
  always_comb begin
    f_in = 1'b0;
    case (mode)
      0: f_in = vars_out[4];
      1: f_in = 1'b0;
      2: f_in = on_mask[vars_out] ^ (vars_out < 5'd2);
      default: f_in = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (done)   done_seen++;
    if (fvalid) fv_seen++;
  end

  minterm_sweep_ctrl #(.N_VARS(N_VARS)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .on_mask_i        (on_mask),
    .dc_mask_i        (dc_mask),
    .vars_out_o       (vars_out),
    .f_in_i           (f_in),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass_o),
    .mismatch_cnt_o   (mcnt),
    .first_fail_idx_o (first_idx),
    .fail_valid_o     (fvalid),
    .fail_ready_i     (fready),
    .fail_idx_o       (fidx),
    .fail_got_o       (fgot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vars"},   {27'd0, vars_out}, 32'd0);
    chk({tag, ".busy"},   {31'd0, busy},     32'd0);
    chk({tag, ".done"},   {31'd0, done},     32'd0);
    chk({tag, ".pass"},   {31'd0, pass_o},   32'd0);
    chk({tag, ".cnt"},    {26'd0, mcnt},     32'd0);
    chk({tag, ".first"},  {27'd0, first_idx}, 32'd0);
    chk({tag, ".fvalid"}, {31'd0, fvalid},   32'd0);
    chk({tag, ".fidx"},   {27'd0, fidx},     32'd0);
    chk({tag, ".fgot"},   {31'd0, fgot},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    on_mask = 32'd0; dc_mask = 32'd0; fready = 1'b0; mode = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("idle");

    // 1: correct function, no mismatches
    mode = 0; on_mask = 32'hFFFF0000; dc_mask = 32'd0; fready = 1'b1;
    snap = fv_seen;
    do_start();
    chk("t1.busy1", {31'd0, busy}, 32'd1);
    chk("t1.vars1", {27'd0, vars_out}, 32'd0);
    go_to(32);
    chk("t1.vars32", {27'd0, vars_out}, 32'd31);
    chk("t1.done32", {31'd0, done}, 32'd0);
    go_to(33);
    chk("t1.done33", {31'd0, done}, 32'd1);
    chk("t1.busy33", {31'd0, busy}, 32'd0);
    chk("t1.pass", {31'd0, pass_o}, 32'd1);
    chk("t1.cnt", {26'd0, mcnt}, 32'd0);
    go_to(34);
    chk("t1.done34", {31'd0, done}, 32'd0);
    chk("t1.nofail", fv_seen - snap, 32'd0);

    // 2: stuck-at-0, two back-to-back reports
    mode = 1; on_mask = 32'h00000003;
    do_start();
    go_to(2);
    chk("t2.fv2", {31'd0, fvalid}, 32'd1);
    chk("t2.fidx2", {27'd0, fidx}, 32'd0);
    chk("t2.fgot2", {31'd0, fgot}, 32'd0);
    go_to(3);
    chk("t2.fv3", {31'd0, fvalid}, 32'd1);
    chk("t2.fidx3", {27'd0, fidx}, 32'd1);
    go_to(4);
    chk("t2.fv4", {31'd0, fvalid}, 32'd0);
    go_to(33);
    chk("t2.done", {31'd0, done}, 32'd1);
    chk("t2.pass", {31'd0, pass_o}, 32'd0);
    chk("t2.cnt", {26'd0, mcnt}, 32'd2);
    chk("t2.first", {27'd0, first_idx}, 32'd0);
    go_to(34);

    // 3: same with those indices marked don't-care
    dc_mask = 32'h00000003;
    snap = fv_seen;
    do_start();
    go_to(33);
    chk("t3.done", {31'd0, done}, 32'd1);
    chk("t3.pass", {31'd0, pass_o}, 32'd1);
    chk("t3.cnt", {26'd0, mcnt}, 32'd0);
    chk("t3.nofail", fv_seen - snap, 32'd0);
    go_to(34);

    // 4: backpressure stall on idx 1
    mode = 2; on_mask = 32'hFFFF0000; dc_mask = 32'd0; fready = 1'b0;
    do_start();
    go_to(2);
    chk("t4.fv2", {31'd0, fvalid}, 32'd1);
    chk("t4.vars2", {27'd0, vars_out}, 32'd1);
    go_to(3);
    chk("t4.vars3", {27'd0, vars_out}, 32'd1);
    chk("t4.busy3", {31'd0, busy}, 32'd1);
    go_to(10);
    chk("t4.vars10", {27'd0, vars_out}, 32'd1);
    chk("t4.fidx10", {27'd0, fidx}, 32'd0);
    chk("t4.fgot10", {31'd0, fgot}, 32'd1);
    chk("t4.cnt10", {26'd0, mcnt}, 32'd1);
    fready = 1'b1;
    go_to(11);
    chk("t4.vars11", {27'd0, vars_out}, 32'd2);
    chk("t4.cnt11", {26'd0, mcnt}, 32'd2);
    chk("t4.fidx11", {27'd0, fidx}, 32'd1);
    chk("t4.fv11", {31'd0, fvalid}, 32'd1);
    go_to(12);
    chk("t4.fv12", {31'd0, fvalid}, 32'd0);
    go_to(40);
    chk("t4.done40", {31'd0, done}, 32'd0);
    go_to(41);
    chk("t4.done41", {31'd0, done}, 32'd1);
    chk("t4.pass", {31'd0, pass_o}, 32'd0);
    chk("t4.first", {27'd0, first_idx}, 32'd0);
    go_to(42);

    // 5: abort with a stray start mid-sweep
    mode = 1; on_mask = 32'h0000000F;
    snap = done_seen;
    do_start();
    go_to(5);
    start_i = 1'b1;
    go_to(6);
    start_i = 1'b0;
    chk("t5.vars6", {27'd0, vars_out}, 32'd5);
    go_to(10);
    abort_i = 1'b1;
    go_to(11);
    abort_i = 1'b0;
    chk("t5.busy", {31'd0, busy}, 32'd0);
    chk("t5.vars", {27'd0, vars_out}, 32'd0);
    chk("t5.pass", {31'd0, pass_o}, 32'd0);
    chk("t5.cnt", {26'd0, mcnt}, 32'd4);
    chk("t5.first", {27'd0, first_idx}, 32'd0);
    go_to(50);
    chk("t5.nodone", done_seen - snap, 32'd0);

    // 6: reset mid-sweep then a clean sweep
    on_mask = 32'h00000003; fready = 1'b0;
    do_start();
    go_to(20);
    rst = 1'b1;
    go_to(21);
    chk_all_zero("t6.rst");
    rst = 1'b0; fready = 1'b1;
    mode = 0; on_mask = 32'hFFFF0000;
    tick();
    do_start();
    go_to(33);
    chk("t6.done", {31'd0, done}, 32'd1);
    chk("t6.pass", {31'd0, pass_o}, 32'd1);
    chk("t6.cnt", {26'd0, mcnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
